// File: rtl/av_palette_pkg.sv
// av_palette_pkg: shared types and constants for the
// Adventure Vision palette loader.
package av_palette_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } pal_state_t;

  localparam logic [127:0] DEFAULT_PAL =
    128'h828214517356305A5F1A3B4900000000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Byte idx of a palette image, byte 0 in the top bits.
  function automatic logic [7:0] pal_byte(
    input logic [127:0] pal,
    input int           idx
  );
    return pal[127 - 8*idx -: 8];
  endfunction

endpackage

// File: rtl/av_palette_loader.sv
// av_palette_loader: captures a palette file into a shadow
// buffer, validates it and commits it at a frame boundary.
module av_palette_loader
  import av_palette_pkg::*;
#(
  parameter int PAL_BYTES = 16,
  parameter int FG_OFFSET = 0,
  parameter int BG_OFFSET = 9,
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk_11m_i,
  input  logic        reset_n_i,
  input  logic        dl_active_i,
  input  logic        dl_wr_i,
  input  logic [24:0] dl_addr_i,
  input  logic [7:0]  dl_data_i,
  input  logic        vblank_i,
  input  logic        use_pal_i,
  output logic [23:0] fg_o,
  output logic [23:0] bg_o,
  output logic        pal_loaded_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(PAL_BYTES);

  localparam rgb_t DEF_FG = {
    pal_byte(DEFAULT_PAL, FG_OFFSET),
    pal_byte(DEFAULT_PAL, FG_OFFSET + 1),
    pal_byte(DEFAULT_PAL, FG_OFFSET + 2)
  };
  localparam rgb_t DEF_BG = {
    pal_byte(DEFAULT_PAL, BG_OFFSET),
    pal_byte(DEFAULT_PAL, BG_OFFSET + 1),
    pal_byte(DEFAULT_PAL, BG_OFFSET + 2)
  };

  // The counter value written on the commit edge is all ones.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  pal_state_t           state;
  logic [PAL_BYTES-1:0] mask;
  logic                 ovf;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 dl_d;
  logic                 vb_d;
  logic [7:0]           shadow [PAL_BYTES];
  rgb_t                 fg_q;
  rgb_t                 bg_q;
  logic                 loaded_q;
  logic                 err_q;

  logic                 dl_rise;
  logic                 dl_fall;
  logic                 vb_rise;
  logic                 in_range;
  logic [AW-1:0]        idx;
  logic                 commit;
  rgb_t                 new_fg;
  rgb_t                 new_bg;

  assign dl_rise  = dl_active_i & ~dl_d;
  assign dl_fall  = ~dl_active_i & dl_d;
  assign vb_rise  = vblank_i & ~vb_d;
  assign in_range = dl_addr_i < 25'(PAL_BYTES);
  assign idx      = dl_addr_i[AW-1:0];

  // A stalled video path must not hold a palette forever.
  assign commit = vb_rise | ~use_pal_i
                | (cnt == CNT_LAST);

  assign new_fg = {
    shadow[FG_OFFSET],
    shadow[FG_OFFSET + 1],
    shadow[FG_OFFSET + 2]
  };
  assign new_bg = {
    shadow[BG_OFFSET],
    shadow[BG_OFFSET + 1],
    shadow[BG_OFFSET + 2]
  };

  // Shadow buffer: plain registers, contents need no reset.
  always_ff @(posedge clk_11m_i) begin
    if (state == LOAD && dl_wr_i && in_range)
      shadow[idx] <= dl_data_i;
  end

  // Loader FSM, validation and active colour registers.
  always_ff @(posedge clk_11m_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      mask     <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      dl_d     <= 1'b0;
      vb_d     <= 1'b0;
      fg_q     <= DEF_FG;
      bg_q     <= DEF_BG;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      dl_d  <= dl_active_i;
      vb_d  <= vblank_i;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dl_rise) begin
            mask  <= '0;
            ovf   <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (dl_wr_i) begin
            if (in_range)
              mask[idx] <= 1'b1;
            else
              ovf <= 1'b1;
          end
          if (dl_fall) begin
            if (&mask && !ovf) begin
              cnt   <= '0;
              state <= PEND;
            end else begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end
        end
        PEND: begin
          cnt <= cnt + TIMEOUT_W'(1);
          if (commit) begin
            fg_q     <= new_fg;
            bg_q     <= new_bg;
            loaded_q <= 1'b1;
            state    <= IDLE;
          end
          if (dl_rise) begin
            mask  <= '0;
            ovf   <= 1'b0;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fg_o         = fg_q;
  assign bg_o         = bg_q;
  assign pal_loaded_o = loaded_q;
  assign busy_o       = (state != IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_av_palette_loader.sv
// tb_av_palette_loader: table vectors, corner sequences and
// randomized downloads against a file-level palette model.
module tb_av_palette_loader;

  localparam int TW = 10;
  localparam logic [23:0] DFG = 24'h828214;
  localparam logic [23:0] DBG = 24'h1A3B49;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        vblank = 1'b0;
  logic        use_pal = 1'b1;
  logic [23:0] fg_o;
  logic [23:0] bg_o;
  logic        pal_loaded_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  logic [23:0] mdl_fg = DFG;
  logic [23:0] mdl_bg = DBG;
  bit          mdl_loaded = 0;

  int         qa[$];
  logic [7:0] qd[$];

  typedef struct {
    int          n;
    logic [7:0]  base;
    bit          up;
    bit          ok;
    logic [23:0] efg;
    logic [23:0] ebg;
  } vec_t;

  vec_t tbl[4];

  av_palette_loader #(.TIMEOUT_W(TW)) dut (
    .clk_11m_i    (clk),
    .reset_n_i    (reset_n),
    .dl_active_i  (dl_active),
    .dl_wr_i      (dl_wr),
    .dl_addr_i    (dl_addr),
    .dl_data_i    (dl_data),
    .vblank_i     (vblank),
    .use_pal_i    (use_pal),
    .fg_o         (fg_o),
    .bg_o         (bg_o),
    .pal_loaded_o (pal_loaded_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_o) err_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    qa = {};
    qd = {};
    for (int i = 0; i < n; i++) begin
      qa.push_back(i);
      qd.push_back(8'(base + 8'(i)));
    end
  endtask

  task automatic write_bytes();
    foreach (qa[i]) begin
      dl_wr   = 1'b1;
      dl_addr = 25'(qa[i]);
      dl_data = qd[i];
      tick();
      dl_wr = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
  endtask

  task automatic send();
    dl_active = 1'b1;
    tick();
    write_bytes();
  endtask

  task automatic finish(input bit ok,
                        input logic [23:0] nfg,
                        input logic [23:0] nbg,
                        input bit up,
                        input int wait_n);
    logic [23:0] xfg;
    logic [23:0] xbg;
    int e0;
    xfg = ok ? nfg : mdl_fg;
    xbg = ok ? nbg : mdl_bg;
    use_pal = up;
    e0 = err_pulses;
    dl_active = 1'b0;
    tick();
    chk("err_pulse", 32'(err_o), 32'(!ok));
    tick();
    chk("err_count", 32'(err_pulses - e0), 32'(!ok));
    if (ok && up) begin
      chk("busy_pend", 32'(busy_o), 32'd1);
      repeat (wait_n) tick();
      vblank = 1'b1;
      chk("fg_hold", 32'(fg_o), 32'(mdl_fg));
      chk("bg_hold", 32'(bg_o), 32'(mdl_bg));
      tick();
      chk("fg_commit", 32'(fg_o), 32'(xfg));
      chk("bg_commit", 32'(bg_o), 32'(xbg));
      vblank = 1'b0;
      tick();
    end else begin
      chk("fg_now", 32'(fg_o), 32'(xfg));
      chk("bg_now", 32'(bg_o), 32'(xbg));
      repeat (wait_n) tick();
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick();
      chk("fg_after_vb", 32'(fg_o), 32'(xfg));
      chk("bg_after_vb", 32'(bg_o), 32'(xbg));
    end
    if (ok) mdl_loaded = 1;
    mdl_fg = xfg;
    mdl_bg = xbg;
    chk("loaded", 32'(pal_loaded_o), 32'(mdl_loaded));
    chk("busy_end", 32'(busy_o), 32'd0);
    use_pal = 1'b1;
  endtask

  task automatic count_commit(input logic [23:0] efg,
                              output int k);
    dl_active = 1'b0;
    k = 0;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (fg_o === efg) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    int mode;
    int t;
    int j;
    bit ok;
    bit seen[16];
    logic [7:0] img[16];
    bit over;

    tbl[0] = '{16, 8'h10, 1'b1, 1'b1, 24'h101112, 24'h191A1B};
    tbl[1] = '{15, 8'h40, 1'b1, 1'b0, 24'h101112, 24'h191A1B};
    tbl[2] = '{17, 8'h60, 1'b1, 1'b0, 24'h101112, 24'h191A1B};
    tbl[3] = '{16, 8'h20, 1'b0, 1'b1, 24'h202122, 24'h292A2B};

    // reset and idle
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (100) tick();
    chk("rst_fg", 32'(fg_o), 32'(DFG));
    chk("rst_bg", 32'(bg_o), 32'(DBG));
    chk("rst_loaded", 32'(pal_loaded_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    // table vectors
    for (int v = 0; v < 4; v++) begin
      fill(tbl[v].n, tbl[v].base);
      send();
      finish(tbl[v].ok, tbl[v].efg, tbl[v].ebg,
             tbl[v].up, 500);
      chk("tbl_fg", 32'(fg_o), 32'(tbl[v].efg));
      chk("tbl_bg", 32'(bg_o), 32'(tbl[v].ebg));
    end

    // timeout with vblank stuck low
    fill(16, 8'h30);
    send();
    count_commit(24'h303132, k);
    chk("tmo_cycles", 32'(k), 32'(1 << TW));
    chk("tmo_bg", 32'(bg_o), 32'h393A3B);
    mdl_fg = 24'h303132;
    mdl_bg = 24'h393A3B;

    // palette disabled: commits right after PEND entry
    fill(16, 8'h50);
    send();
    use_pal = 1'b0;
    count_commit(24'h505152, k);
    chk("nopal_cycles", 32'(k), 32'd2);
    use_pal = 1'b1;
    mdl_fg = 24'h505152;
    mdl_bg = 24'h595A5B;

    // reset while pending
    fill(16, 8'h70);
    send();
    dl_active = 1'b0;
    repeat (5) tick();
    chk("pend_busy", 32'(busy_o), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("prst_fg", 32'(fg_o), 32'(DFG));
    chk("prst_bg", 32'(bg_o), 32'(DBG));
    chk("prst_loaded", 32'(pal_loaded_o), 32'd0);
    chk("prst_busy", 32'(busy_o), 32'd0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    chk("prst_vb_fg", 32'(fg_o), 32'(DFG));
    mdl_fg = DFG;
    mdl_bg = DBG;
    mdl_loaded = 0;

    // new download while pending discards the palette
    fill(16, 8'h80);
    send();
    dl_active = 1'b0;
    repeat (3) tick();
    dl_active = 1'b1;
    tick();
    tick();
    dl_active = 1'b0;
    tick();
    chk("discard_err", 32'(err_o), 32'd1);
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    chk("discard_fg", 32'(fg_o), 32'(DFG));
    chk("discard_ld", 32'(pal_loaded_o), 32'd0);

    // new download in the same cycle as vblank: commit wins
    fill(16, 8'h90);
    send();
    dl_active = 1'b0;
    repeat (3) tick();
    dl_active = 1'b1;
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("race_fg", 32'(fg_o), 32'h909192);
    chk("race_bg", 32'(bg_o), 32'h999A9B);
    chk("race_busy", 32'(busy_o), 32'd1);
    mdl_fg = 24'h909192;
    mdl_bg = 24'h999A9B;
    mdl_loaded = 1;
    fill(16, 8'hA0);
    write_bytes();
    finish(1'b1, 24'hA0A1A2, 24'hA9AAAB, 1'b1, 20);

    // randomized files against the file-level model
    for (int r = 0; r < 24; r++) begin
      qa = {};
      qd = {};
      for (int i = 0; i < 16; i++) qa.push_back(i);
      for (int i = 15; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = qa[i];
        qa[i] = qa[j];
        qa[j] = t;
      end
      mode = int'($urandom_range(0, 3));
      if (mode == 1)
        qa.delete(int'($urandom_range(0, 15)));
      else if (mode == 2)
        qa.insert(int'($urandom_range(0, 16)),
                  int'($urandom_range(16, 300)));
      else if (mode == 3)
        repeat (3)
          qa.insert(int'($urandom_range(0, 16)),
                    int'($urandom_range(0, 15)));
      foreach (qa[i]) qd.push_back(8'($urandom));
      over = 0;
      for (int i = 0; i < 16; i++) seen[i] = 0;
      foreach (qa[i]) begin
        if (qa[i] < 16) begin
          seen[qa[i]] = 1;
          img[qa[i]] = qd[i];
        end else begin
          over = 1;
        end
      end
      ok = !over;
      for (int i = 0; i < 16; i++) if (!seen[i]) ok = 0;
      send();
      finish(ok, {img[0], img[1], img[2]},
             {img[9], img[10], img[11]},
             1'($urandom_range(0, 1)),
             int'($urandom_range(3, 40)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/av_palette_loader.md
Name: av_palette_loader

Overview:
- Upstream of the colour-substitution logic in the Adventure Vision top level.
- Captures a 16-byte GBP palette file from the HPS download stream into a shadow buffer and validates it (exact length, no overflow).
- Commits a valid palette to the active foreground/background colour registers only at a frame boundary (rising edge of VBlank), so a load never tears mid-frame.
- Replaces the free-running shift register with a checked, double-buffered loader.

Parameters:
- PAL_BYTES, 16, bytes in a complete palette file.
- FG_OFFSET, 0, byte index of the first (R) byte of the foreground colour.
- BG_OFFSET, 9, byte index of the first (R) byte of the background colour.
- DEFAULT_PAL, 128'h828214517356305A5F1A3B4900000000, power-on palette; byte 0 = bits [127:120].
- TIMEOUT_W, 20, width of the commit-timeout counter; forced commit after 2^TIMEOUT_W-1 cycles.

Ports:
- clk_11m_i  in  1  system clock (clk_sys)
- reset_n_i  in  1  reset; synchronous, active-low
- dl_active_i  in  1  palette download in progress (ioctl_download qualified by palette index)
- dl_wr_i  in  1  byte strobe, one cycle per byte
- dl_addr_i  in  25  byte address within the file
- dl_data_i  in  8  byte data
- vblank_i  in  1  VBlank from av_video, clk_11m_i domain
- use_pal_i  in  1  custom palette enabled (status[7])
- fg_o  out  24  active foreground RGB888
- bg_o  out  24  active background RGB888
- pal_loaded_o  out  1  high once any user palette has been committed
- busy_o  out  1  high in LOAD or PEND
- err_o  out  1  one-cycle pulse on a rejected download

Behaviour:
- Reset (reset_n_i low at a clock edge):
  - state <= IDLE, byte mask cleared, timeout counter 0.
  - Active registers loaded from DEFAULT_PAL: fg_o = 24'h828214, bg_o = 24'h1A3B49.
  - pal_loaded_o = 0, busy_o = 0, err_o = 0.
  - Shadow contents don't-care.
  - Reset mid-LOAD or mid-PEND discards the shadow; nothing is committed.
- Edge detection: dl_d and vb_d are registered copies of dl_active_i and vblank_i.
  - dl_rise = dl_active_i & ~dl_d; dl_fall = ~dl_active_i & dl_d; vb_rise = vblank_i & ~vb_d.
- State IDLE:
  - On dl_rise, clear the 16-bit byte mask and the overflow flag, then go to LOAD.
  - A write in the dl_rise cycle is ignored; hps_io guarantees at least one idle cycle first.
- State LOAD:
  - On dl_wr_i with dl_addr_i < PAL_BYTES: shadow[addr] <= dl_data_i and mask[addr] <= 1.
  - Rewriting the same address is allowed; last write wins.
  - On dl_wr_i with dl_addr_i >= PAL_BYTES: overflow <= 1 and the data is dropped.
  - On dl_fall with mask all ones and overflow 0: go to PEND with timeout counter 0.
  - On dl_fall otherwise: pulse err_o for 1 cycle and go to IDLE; the active palette is unchanged.
- State PEND:
  - The counter increments every cycle.
  - Commit when vb_rise is seen, or when use_pal_i = 0 (palette not displayed, so no tear), or when the counter reaches all ones (video stalled).
  - Commit writes fg <= shadow[FG_OFFSET..+2] and bg <= shadow[BG_OFFSET..+2], with byte order R,G,B, and sets pal_loaded_o <= 1. Next state is IDLE.
  - New outputs are visible the cycle after the commit edge. Worst-case latency from dl_fall is one frame plus 1 cycle.
  - dl_rise in PEND without a commit condition in the same cycle: the pending palette is discarded and the state goes to LOAD (mask cleared).
  - dl_rise and a commit condition in the same cycle: the commit wins (shadow still intact), the mask and overflow flag are cleared in that same cycle, and the next state is LOAD.
- busy_o = (state == LOAD) or (state == PEND), registered.
- fg_o and bg_o change only in a commit cycle or at reset. There is no combinational path from dl_* to the outputs.
- dl_wr_i is ignored outside LOAD.

Decomposition:
- av_palette_pkg holds:
  - state enum pal_state_t {IDLE, LOAD, PEND};
  - localparam DEFAULT_PAL;
  - typedef rgb_t (24-bit packed R,G,B);
  - function pal_byte(palette, idx), which extracts byte idx MSB-first.
- No sub-module is needed. The 16x8 shadow is a register array, not a RAM, since it needs simultaneous 3-byte reads.

Test Plan:
- Reset then idle 100 cycles -> fg_o = 828214, bg_o = 1A3B49, pal_loaded_o = 0, busy_o = 0.
- Download bytes 00..0F (byte i = 8'h10+i) and assert vblank 500 cycles after dl_fall, use_pal_i = 1 -> outputs are unchanged until the cycle after vb_rise, then fg_o = 101112 and bg_o = 191A1B; pal_loaded_o = 1; err_o never pulses.
- Download only 15 bytes (addr 0..14) -> err_o pulses exactly once, 1 cycle after dl_fall; fg_o and bg_o keep their previous values; state returns to IDLE.
- Download 17 bytes (addr 0..16) -> overflow is flagged, err_o pulses, no commit occurs even after vb_rise.
- Valid download with vblank_i held low and use_pal_i = 1 -> commit happens exactly 2^20-1 cycles after PEND entry; repeat with use_pal_i = 0 -> commit happens 1 cycle after PEND entry.
- Valid download, then reset_n_i low for 1 cycle while in PEND -> outputs return to the defaults, pal_loaded_o = 0, and no commit occurs at the next vb_rise.
